pc_sequencer: RTL and testbench

- Owns the program counter register and sequences the PC-increment and branch-target adders for the fetch stage.
- Selects the next PC from sequential, branch, jump or register-jump sources, and runs the request/ready handshake with instruction memory.
- Holds the PC on pipeline stalls; any redirect that arrives during an outstanding fetch is held until that fetch completes.
- Sits between the control unit and instruction memory; replaces the free-running PC+4 path.

---
 rtl/pc_seq_pkg.sv | 23 ++
 rtl/next_pc_calc.sv | 48 ++++
 rtl/pc_sequencer.sv | 131 +++++++++++++
 tb/tb_pc_sequencer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// Shared types and defaults for the fetch-stage PC sequencer.
package pc_seq_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam int unsigned PC_STEP_DEF  = 4;

  // Sequencer states: one idle cycle after reset, then fetch or stall.
  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_STALL = 2'd2
  } state_e;

  // Redirect kinds; the numeric order is the priority order, so a plain
  // magnitude compare decides whether a new redirect beats a held one.
  typedef enum logic [1:0] {
    RD_NONE = 2'd0,
    RD_BR   = 2'd1,
    RD_J    = 2'd2,
    RD_JR   = 2'd3
  } redir_e;

endpackage

// File: rtl/next_pc_calc.sv
// Next-PC arithmetic: sequential increment, branch/jump/jr targets and the
// priority-selected redirect (jr > jump > branch > none).
module next_pc_calc
  import pc_seq_pkg::*;
#(
  parameter int unsigned PC_STEP = PC_STEP_DEF
) (
  input  logic [31:0] pc_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_offset_i,
  input  logic        jump_i,
  input  logic [25:0] jump_index_i,
  input  logic        jr_i,
  input  logic [31:0] jr_target_i,
  output logic [31:0] pc_plus4_o,
  output redir_e      sel_kind_o,
  output logic [31:0] sel_target_o
);

  logic [31:0] br_target;
  logic [31:0] j_target;
  logic [31:0] jr_aligned;

  // All sums are modulo 2^32; carries out of bit 31 are simply dropped.
  assign pc_plus4_o = pc_i + 32'(PC_STEP);
  assign br_target  = pc_plus4_o + {branch_offset_i[29:0], 2'b00};
  assign j_target   = {pc_plus4_o[31:28], jump_index_i, 2'b00};
  assign jr_aligned = {jr_target_i[31:2], 2'b00};

  // Pick the highest-priority redirect requested this cycle.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    sel_kind_o   = RD_NONE;
    sel_target_o = pc_plus4_o;
    if (jr_i) begin
      sel_kind_o   = RD_JR;
      sel_target_o = jr_aligned;
    end else if (jump_i) begin
      sel_kind_o   = RD_J;
      sel_target_o = j_target;
    end else if (branch_taken_i) begin
      sel_kind_o   = RD_BR;
      sel_target_o = br_target;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage PC sequencer: owns the PC, runs the imem request/ready
// handshake, holds on stalls and defers redirects that arrive while a fetch
// is outstanding or the pipeline is stalled.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int unsigned PC_STEP  = PC_STEP_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        imem_ready,
  input  logic        branch_taken,
  input  logic [31:0] branch_offset,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        jr,
  input  logic [31:0] jr_target,
  output logic        imem_req,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        instr_valid,
  output logic        redirect,
  output logic        misalign
);

  state_e      state_q;
  logic [31:0] pc_q;
  logic        imem_req_q;
  logic        instr_valid_q;
  logic        redirect_q;
  logic        misalign_q;
  redir_e      pend_kind_q;
  logic [31:0] pend_target_q;

  redir_e      sel_kind;
  logic [31:0] sel_target;
  logic        take_pend;
  redir_e      pend_kind_d;
  logic [31:0] pend_target_d;

  next_pc_calc #(.PC_STEP(PC_STEP)) u_calc (
    .pc_i            (pc_q),
    .branch_taken_i  (branch_taken),
    .branch_offset_i (branch_offset),
    .jump_i          (jump),
    .jump_index_i    (jump_index),
    .jr_i            (jr),
    .jr_target_i     (jr_target),
    .pc_plus4_o      (pc_plus4),
    .sel_kind_o      (sel_kind),
    .sel_target_o    (sel_target)
  );

  // Pending-register update while the PC cannot move: a new redirect replaces
  // the held one unless the held one has strictly higher priority.
  assign take_pend     = (sel_kind != RD_NONE) && (sel_kind >= pend_kind_q);
  assign pend_kind_d   = take_pend ? sel_kind   : pend_kind_q;
  assign pend_target_d = take_pend ? sel_target : pend_target_q;

  // Sequencer FSM with PC, pending redirect and registered output pulses.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_BOOT;
      pc_q          <= RESET_PC;
      imem_req_q    <= 1'b0;
      instr_valid_q <= 1'b0;
      redirect_q    <= 1'b0;
      misalign_q    <= 1'b0;
      pend_kind_q   <= RD_NONE;
      pend_target_q <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register samples
      // the pre-edge values regardless of statement order.
      instr_valid_q <= 1'b0;
      redirect_q    <= 1'b0;
      if (jr && (jr_target[1:0] != 2'b00)) begin
        misalign_q <= 1'b1;
      end
      unique case (state_q)
        ST_BOOT: begin
          state_q    <= ST_FETCH;
          imem_req_q <= 1'b1;
        end
        ST_FETCH: begin
          if (imem_ready) begin
            instr_valid_q <= 1'b1;
            pend_kind_q   <= RD_NONE;
            if (pend_kind_q != RD_NONE) begin
              pc_q       <= pend_target_q;
              redirect_q <= 1'b1;
            end else if (sel_kind != RD_NONE) begin
              pc_q       <= sel_target;
              redirect_q <= 1'b1;
            end else begin
              pc_q <= pc_plus4;
            end
            // A stall during an outstanding fetch only bites once it completes.
            if (stall) begin
              state_q    <= ST_STALL;
              imem_req_q <= 1'b0;
            end
          end else begin
            pend_kind_q   <= pend_kind_d;
            pend_target_q <= pend_target_d;
          end
        end
        ST_STALL: begin
          pend_kind_q   <= pend_kind_d;
          pend_target_q <= pend_target_d;
          if (!stall) begin
            state_q    <= ST_FETCH;
            imem_req_q <= 1'b1;
          end
        end
        default: begin
          state_q    <= ST_BOOT;
          imem_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = imem_req_q;
  assign pc          = pc_q;
  assign instr_valid = instr_valid_q;
  assign redirect    = redirect_q;
  assign misalign    = misalign_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// behavioural model.
module tb_pc_sequencer;

  logic        clock = 1'b0;
  logic        reset, stall, imem_ready, branch_taken, jump, jr;
  logic [31:0] branch_offset, jr_target;
  logic [25:0] jump_index;
  logic        imem_req, instr_valid, redirect, misalign;
  logic [31:0] pc, pc_plus4;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en   = 1'b0;

  // Behavioural model state (values the DUT outputs must show after an edge).
  logic [31:0] m_pc;
  bit          m_booting, m_stalled, m_iv, m_rd, m_mis;
  int          m_pend_rank;   // 0 = nothing held, 1 branch, 2 jump, 3 jr
  logic [31:0] m_pend_pc;

  pc_sequencer dut (
    .clock         (clock),
    .reset         (reset),
    .stall         (stall),
    .imem_ready    (imem_ready),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .jump          (jump),
    .jump_index    (jump_index),
    .jr            (jr),
    .jr_target     (jr_target),
    .imem_req      (imem_req),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .instr_valid   (instr_valid),
    .redirect      (redirect),
    .misalign      (misalign)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_update();
    logic [31:0] next_seq, tgt;
    int          rank;
    if (reset) begin
      m_pc = 32'h0; m_booting = 1; m_stalled = 0;
      m_iv = 0; m_rd = 0; m_mis = 0; m_pend_rank = 0; m_pend_pc = 32'h0;
      return;
    end
    next_seq = m_pc + 32'd4;
    m_iv = 0;
    m_rd = 0;
    if (jr && (jr_target % 4 != 0)) m_mis = 1;
    rank = 0;
    tgt  = next_seq;
    if (jr) begin
      rank = 3; tgt = jr_target & ~32'd3;
    end else if (jump) begin
      rank = 2; tgt = (next_seq & 32'hF000_0000) | (32'(jump_index) * 4);
    end else if (branch_taken) begin
      rank = 1; tgt = next_seq + branch_offset * 4;
    end
    if (m_booting) begin
      m_booting = 0;
    end else if (m_stalled || !imem_ready) begin
      if (rank > 0 && rank >= m_pend_rank) begin
        m_pend_rank = rank;
        m_pend_pc   = tgt;
      end
      if (m_stalled && !stall) m_stalled = 0;
    end else begin
      m_iv = 1;
      if (m_pend_rank > 0) begin
        m_pc = m_pend_pc; m_rd = 1;
      end else if (rank > 0) begin
        m_pc = tgt; m_rd = 1;
      end else begin
        m_pc = next_seq;
      end
      m_pend_rank = 0;
      m_stalled   = stall;
    end
  endtask

  // Every cycle once the model is seeded: all outputs against the model.
  always @(negedge clock) begin
    if (cmp_en) begin
      check("pc", pc, m_pc);
      check("pc_plus4", pc_plus4, m_pc + 32'd4);
      check("imem_req", 32'(imem_req), 32'(!m_booting && !m_stalled));
      check("instr_valid", 32'(instr_valid), 32'(m_iv));
      check("redirect", 32'(redirect), 32'(m_rd));
      check("misalign", 32'(misalign), 32'(m_mis));
    end
  end

  task automatic idle();
    reset = 0; stall = 0; imem_ready = 0; branch_taken = 0; jump = 0; jr = 0;
    branch_offset = 32'h0; jump_index = 26'h0; jr_target = 32'h0;
  endtask

  // Apply the current inputs across one rising edge, then settle the model.
  task automatic step();
    @(posedge clock);
    #1;
    model_update();
    cmp_en = 1'b1;
  endtask

  task automatic go_jr(input logic [31:0] tgt);
    idle(); imem_ready = 1; jr = 1; jr_target = tgt; step();
  endtask

  initial begin
    idle();
    reset = 1;
    @(negedge clock);
    step();
    // Reset state.
    check("rst_pc", pc, 32'h0);
    check("rst_req", 32'(imem_req), 32'h0);
    check("rst_misalign", 32'(misalign), 32'h0);

    // Scenario 1: sequential fetches from reset.
    idle(); step();                       // BOOT -> FETCH
    check("boot_req", 32'(imem_req), 32'h1);
    check("boot_pc", pc, 32'h0);
    for (int i = 1; i <= 3; i++) begin
      idle(); imem_ready = 1; step();
      check("seq_pc", pc, 32'(4 * i));
      check("seq_iv", 32'(instr_valid), 32'h1);
    end

    // Scenario 2: taken branch with a negative offset.
    go_jr(32'h0000_0040);
    idle(); imem_ready = 1; branch_taken = 1; branch_offset = 32'hFFFF_FFFE; step();
    check("br_pc", pc, 32'h0000_003C);
    check("br_redirect", 32'(redirect), 32'h1);
    idle(); imem_ready = 1; step();
    check("br_redirect_pulse", 32'(redirect), 32'h0);

    // Scenario 3: jr beats jump in the same cycle; misalign sticks.
    go_jr(32'hF000_0010);
    check("jr_setup_pc", pc, 32'hF000_0010);
    idle(); imem_ready = 1; jump = 1; jump_index = 26'h0000100;
    jr = 1; jr_target = 32'h0000_1003; step();
    check("jr_pc", pc, 32'h0000_1000);
    check("jr_misalign", 32'(misalign), 32'h1);

    // Scenario 4: jump held pending across a slow fetch.
    idle(); jump = 1; jump_index = 26'h10; step();
    for (int i = 0; i < 2; i++) begin
      idle(); step();
      check("wait_pc", pc, 32'h0000_1000);
      check("wait_req", 32'(imem_req), 32'h1);
    end
    idle(); imem_ready = 1; step();
    check("pend_pc", pc, 32'h0000_0040);
    check("pend_redirect", 32'(redirect), 32'h1);
    check("misalign_sticky", 32'(misalign), 32'h1);
    idle(); step();
    check("pend_redirect_pulse", 32'(redirect), 32'h0);

    // Scenario 5: stall after a completed fetch, then resume.
    go_jr(32'h0000_001C);
    idle(); imem_ready = 1; stall = 1; step();
    check("stall_entry_pc", pc, 32'h0000_0020);
    idle(); imem_ready = 1; stall = 1; step();
    check("stall_req", 32'(imem_req), 32'h0);
    check("stall_pc", pc, 32'h0000_0020);
    idle(); step();
    check("resume_req", 32'(imem_req), 32'h1);
    idle(); imem_ready = 1; step();
    check("resume_pc", pc, 32'h0000_0024);

    // Scenario 6: wrap at the top of memory, then reset mid-wait.
    go_jr(32'hFFFF_FFFC);
    check("wrap_plus4", pc_plus4, 32'h0);
    idle(); imem_ready = 1; step();
    check("wrap_pc", pc, 32'h0);
    idle(); jump = 1; jump_index = 26'h55; step();
    idle(); reset = 1; step();
    check("midrst_pc", pc, 32'h0);
    check("midrst_req", 32'(imem_req), 32'h0);
    check("midrst_misalign", 32'(misalign), 32'h0);
    idle(); step();
    idle(); imem_ready = 1; step();
    check("post_rst_pc", pc, 32'h4);
    check("post_rst_redirect", 32'(redirect), 32'h0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      idle();
      reset         = ($urandom_range(99) == 0);
      stall         = ($urandom_range(4) == 0);
      imem_ready    = ($urandom_range(4) < 3);
      branch_taken  = ($urandom_range(5) == 0);
      branch_offset = $urandom() | 32'h1;
      jump          = ($urandom_range(7) == 0);
      jump_index    = 26'($urandom());
      jr            = ($urandom_range(9) == 0);
      jr_target     = $urandom();
      if ($urandom_range(1) == 0) jr_target = jr_target & ~32'd3;
      step();
    end

    @(posedge clock);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
